// File: rtl/free_list_ctrl.sv
// Rename-stage free-list controller: in-order PRN grants, retire pushes,
// and squash recovery sequencing against a shadow free count.
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif
`ifndef FREE_LIST_CTR_WIDTH
`define FREE_LIST_CTR_WIDTH 7
`endif
`ifndef FREE_LIST_PACKET_W
`define FREE_LIST_PACKET_W 7
`endif

module free_list_ctrl #(
  parameter int N              = 3,
  parameter int SIZE           = `PHYS_REG_SZ_R10K,
  parameter int ARCH           = `ARCH_REG_SZ,
  parameter int RECOVER_CYCLES = 2,
  parameter int CW             = `FREE_LIST_CTR_WIDTH,
  parameter int PW             = `FREE_LIST_PACKET_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [N-1:0]  dis_req,
  output logic [N-1:0]  dis_grant,
  output logic          dis_stall,
  input  logic [N*PW-1:0] ret_packet,
  output logic          ret_ready,
  input  logic          squash_req,
  input  logic [CW-1:0] rrat_counter,
  output logic [N-1:0]  fl_pop_en,
  output logic [N*PW-1:0] fl_push_packet,
  output logic          fl_rat_squash,
  output logic [CW-1:0] free_count,
  output logic          recovering,
  output logic          overflow_err
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RESTORE = 2'd1;
  localparam logic [1:0] SETTLE  = 2'd2;

  localparam logic [CW:0] ONE    = (CW+1)'(1);
  localparam logic [CW:0] SIZE_W = (CW+1)'(SIZE);
  localparam logic [3:0]  LOAD   = 4'(RECOVER_CYCLES-1);

  logic [1:0]    state, state_nxt;
  logic [3:0]    settle_cnt, settle_nxt;
  logic [CW:0]   taken, run;
  logic [CW-1:0] count_nxt;
  logic          blocked, push_v, ovf;

  assign fl_rat_squash = (state == RESTORE);
  assign ret_ready     = (state != RESTORE);
  assign recovering    = (state != IDLE);
  assign fl_pop_en     = dis_grant;
  assign dis_stall     = |(dis_req & ~dis_grant);

  // Once a requesting lane is refused, every higher lane is refused too.
  always_comb begin
    dis_grant = '0;
    taken     = '0;
    blocked   = 1'b0;
    if (state == IDLE && !squash_req) begin
      for (int i = 0; i < N; i++) begin
        if (dis_req[i]) begin
          if (!blocked && (taken + ONE) <= {1'b0, free_count}) begin
            dis_grant[i] = 1'b1;
            taken        = taken + ONE;
          end else begin
            blocked = 1'b1;
          end
        end
      end
    end
  end

  // Pops land first, then pushes in lane order, saturating at SIZE.
  always_comb begin
    fl_push_packet = ret_packet;
    run            = {1'b0, free_count} - taken;
    ovf            = 1'b0;
    push_v         = 1'b0;
    for (int i = 0; i < N; i++) begin
      push_v = ret_packet[i*PW+PW-1] & ret_ready;
      fl_push_packet[i*PW+PW-1] = push_v;
      if (push_v) begin
        if (run < SIZE_W) run = run + ONE;
        else              ovf = 1'b1;
      end
    end
    count_nxt = (state == RESTORE) ? rrat_counter : run[CW-1:0];
  end

  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    unique case (state)
      IDLE: begin
        if (squash_req) state_nxt = RESTORE;
      end
      RESTORE: begin
        state_nxt  = SETTLE;
        settle_nxt = LOAD;
      end
      SETTLE: begin
        if (squash_req) begin
          state_nxt = RESTORE;
        end else if (settle_cnt == 4'd0) begin
          state_nxt = IDLE;
        end else begin
          settle_nxt = settle_cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      free_count   <= CW'(SIZE - ARCH);
      overflow_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= settle_nxt;
      free_count <= count_nxt;
      if (ovf) overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_free_list_ctrl.sv
// Randomized bench for free_list_ctrl against a count/recovery-timer model.
module tb_free_list_ctrl;

  localparam int N    = 3;
  localparam int SIZE = 64;
  localparam int ARCH = 32;
  localparam int RC   = 2;
  localparam int CW   = 7;
  localparam int PW   = 7;

  logic            clock = 1'b0;
  logic            reset;
  logic [N-1:0]    dis_req;
  logic [N-1:0]    dis_grant;
  logic            dis_stall;
  logic [N*PW-1:0] ret_packet;
  logic            ret_ready;
  logic            squash_req;
  logic [CW-1:0]   rrat_counter;
  logic [N-1:0]    fl_pop_en;
  logic [N*PW-1:0] fl_push_packet;
  logic            fl_rat_squash;
  logic [CW-1:0]   free_count;
  logic            recovering;
  logic            overflow_err;

  free_list_ctrl #(
    .N(N), .SIZE(SIZE), .ARCH(ARCH),
    .RECOVER_CYCLES(RC), .CW(CW), .PW(PW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .dis_req(dis_req),
    .dis_grant(dis_grant),
    .dis_stall(dis_stall),
    .ret_packet(ret_packet),
    .ret_ready(ret_ready),
    .squash_req(squash_req),
    .rrat_counter(rrat_counter),
    .fl_pop_en(fl_pop_en),
    .fl_push_packet(fl_push_packet),
    .fl_rat_squash(fl_rat_squash),
    .free_count(free_count),
    .recovering(recovering),
    .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int errors  = 0;

  // m_rec counts remaining non-idle cycles; RC+1 marks the restore cycle.
  int m_cnt;
  int m_rec;
  bit m_ovf;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*PW-1:0] mk(input logic [N-1:0] v);
    logic [N*PW-1:0] p;
    for (int i = 0; i < N; i++)
      p[i*PW +: PW] = {v[i], 6'($urandom)};
    return p;
  endfunction

  task automatic step(input logic [N-1:0] rq, input logic [N*PW-1:0] rp,
                      input logic sq, input logic [CW-1:0] rr);
    int avail, g, c, ncnt, nrec;
    logic [N-1:0] eg;
    logic [N*PW-1:0] ep;
    bit restore, eovf, v;
    @(negedge clock);
    dis_req = rq; ret_packet = rp; squash_req = sq; rrat_counter = rr;
    #1;
    restore = (m_rec == RC+1);
    avail = (m_rec == 0 && !sq) ? m_cnt : 0;
    g = 0; eg = '0;
    for (int i = 0; i < N; i++)
      if (rq[i] && g < avail) begin
        eg[i] = 1'b1;
        g++;
      end
    ep = rp; c = m_cnt - g; eovf = m_ovf;
    for (int i = 0; i < N; i++) begin
      v = rp[i*PW+PW-1] && !restore;
      ep[i*PW+PW-1] = v;
      if (v) begin
        if (c < SIZE) c++;
        else eovf = 1'b1;
      end
    end
    chk("grant", dis_grant, eg);
    chk("pop_en", fl_pop_en, eg);
    chk("stall", dis_stall, |(rq & ~eg));
    chk("ret_ready", ret_ready, !restore);
    chk("rat_squash", fl_rat_squash, restore);
    chk("recovering", recovering, m_rec != 0);
    chk("free_count", free_count, m_cnt);
    chk("overflow", overflow_err, m_ovf);
    chk("push_pkt", fl_push_packet, ep);
    ncnt = restore ? int'(rr) : c;
    nrec = (sq && !restore) ? RC+1 : (m_rec > 0 ? m_rec-1 : 0);
    @(posedge clock);
    m_cnt = ncnt; m_rec = nrec; m_ovf = eovf;
  endtask

  task automatic reset_checks(input string tag);
    m_cnt = SIZE - ARCH; m_rec = 0; m_ovf = 1'b0;
    chk({tag, "_count"}, free_count, m_cnt);
    chk({tag, "_recovering"}, recovering, 1'b0);
    chk({tag, "_ret_ready"}, ret_ready, 1'b1);
    chk({tag, "_grant"}, dis_grant, '0);
    chk({tag, "_overflow"}, overflow_err, 1'b0);
    chk({tag, "_rat_squash"}, fl_rat_squash, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #1 reset = 1'b0;
    dis_req = '0; ret_packet = '0; squash_req = 1'b0; rrat_counter = '0;
    #1 reset_checks("rst");
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    int guard;
    logic [N-1:0] rq, vm;
    bit heavy;
    reset = 1'b0;
    dis_req = '0; ret_packet = '0; squash_req = 1'b0; rrat_counter = '0;
    apply_reset();

    repeat (10) step(3'b111, '0, 1'b0, '0);
    step(3'b111, '0, 1'b0, '0);
    step(3'b001, mk(3'b001), 1'b0, '0);
    step(3'b001, '0, 1'b0, '0);
    step(3'b000, mk(3'b010), 1'b0, '0);
    step(3'b101, '0, 1'b0, '0);
    repeat (3) step(3'b000, mk(3'b111), 1'b0, '0);

    step(3'b111, '0, 1'b1, 7'd29);
    repeat (4) step(3'b111, mk(3'b001), 1'b0, '0);
    step(3'b011, '0, 1'b1, 7'd20);
    step(3'b011, '0, 1'b0, '0);
    step(3'b011, '0, 1'b1, 7'd12);
    repeat (5) step(3'b011, mk(3'b100), 1'b0, '0);

    for (int k = 0; k < 600; k++) begin
      heavy = ((k / 60) % 2) == 1;
      rq = heavy ? 3'($urandom & $urandom) : 3'($urandom);
      vm = heavy ? 3'($urandom | $urandom) : 3'($urandom & $urandom);
      step(rq, mk(vm), $urandom_range(0, 31) == 0,
           7'($urandom_range(0, SIZE)));
    end

    apply_reset();
    guard = 0;
    while (m_cnt < SIZE-1 && guard < 200) begin
      step(3'b000, mk(3'b001), 1'b0, '0);
      guard++;
    end
    chk("fill_bound", guard < 200, 1'b1);
    step(3'b000, mk(3'b011), 1'b0, '0);
    repeat (3) step(3'b000, mk(3'b000), 1'b0, '0);
    step(3'b111, mk(3'b101), 1'b0, '0);

    step(3'b000, '0, 1'b1, 7'd10);
    step(3'b000, '0, 1'b0, '0);
    @(negedge clock);
    #1 reset = 1'b0;
    #1 reset_checks("midrec");
    @(negedge clock);
    reset = 1'b1;
    repeat (8)
      step(3'($urandom), mk(3'($urandom)), 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
